// File: rtl/lsu_stage_pkg.sv
// Shared LSU definitions: data widths, MemOP encodings, FSM states and size helpers.
package lsu_stage_pkg;

    localparam int RegWidth = 64;
    localparam int InstWide = 32;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_D  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_WU = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Byte strobes for an access of the given size code (MemOP[1:0]) at offset 0.
    function automatic logic [7:0] sizeMask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] offset);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = offset[0];
            2'b10:   bad = |offset[1:0];
            default: bad = |offset;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: shifts the 8-byte response beat down to the accessed
// byte lane and sign- or zero-extends according to MemOP.
module lsu_load_align
    import lsu_stage_pkg::*;
#(
    parameter int XLEN = RegWidth
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_offset,
    input  logic [2:0]      i_MemOP,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_MemOP)
            MEMOP_B:  o_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            MEMOP_H:  o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            MEMOP_W:  o_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            MEMOP_D:  o_data = w_shifted;
            MEMOP_BU: o_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            MEMOP_HU: o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            MEMOP_WU: o_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default:  o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: EX->LSU accept, req/resp memory access, LSU->WB handshake.
// Optional alignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int XLEN = RegWidth,
    parameter int ILEN = InstWide
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ex_to_lsu_valid,
    output logic            lsu_allow_in,
    input  logic [XLEN-1:0] i_ALUres,
    input  logic [XLEN-1:0] i_R_rs2,
    input  logic            i_MemRd,
    input  logic            i_MemWr,
    input  logic [2:0]      i_MemOP,
    input  logic            i_RegSrc,
    input  logic            i_RegWr,
    input  logic            i_isecall,
    input  logic            i_ismret,
    input  logic            i_iscsr,
    input  logic            i_clint_mtip,
    input  logic [XLEN-1:0] i_R_rs1,
    input  logic [XLEN-1:0] i_pc,
    input  logic [ILEN-1:0] i_inst,

    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_wen,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_wmask,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_rdata,

    output logic            lsu_to_wb_valid,
    input  logic            wb_allow_in,
    output logic [XLEN-1:0] MemOut,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_ALUres,
    output logic            o_RegSrc,
    output logic            o_RegWr,
    output logic            o_isecall,
    output logic            o_ismret,
    output logic            o_iscsr,
    output logic            o_clint_mtip,
    output logic [XLEN-1:0] o_R_rs1,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_inst
);

    lsu_state_e      r_state;
    lsu_state_e      w_nextState;
    lsu_state_e      w_acceptTarget;

    logic            w_accept;
    logic            w_isMem;
    logic            w_misalign;
    logic [XLEN-1:0] w_storeData;
    logic [7:0]      w_storeMask;
    logic [XLEN-1:0] w_loadData;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_wmask;
    logic            r_wen;
    logic            r_memRd;
    logic [2:0]      r_memOp;
    logic [XLEN-1:0] r_memOut;
    logic            r_RegSrc;
    logic            r_RegWr;
    logic            r_isecall;
    logic            r_ismret;
    logic            r_iscsr;
    logic            r_clint_mtip;
    logic [XLEN-1:0] r_R_rs1;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_inst;

    assign w_accept    = ex_to_lsu_valid && lsu_allow_in;
    assign w_isMem     = i_MemRd || i_MemWr;
    assign w_storeData = i_R_rs2 << {i_ALUres[2:0], 3'b000};
    // Strobes past byte 7 are shifted out of the 8-bit result and dropped.
    assign w_storeMask = sizeMask(i_MemOP[1:0]) << i_ALUres[2:0];

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign = w_isMem && isMisaligned(i_MemOP[1:0], i_ALUres[2:0]);
    assign o_misalign = r_misalign;
`else
    assign w_misalign = 1'b0;
    assign o_misalign = 1'b0;
`endif

    // A misaligned access skips the bus and reports straight away.
    assign w_acceptTarget = (w_isMem && !w_misalign) ? LSU_REQ : LSU_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept)   w_nextState = w_acceptTarget;
            LSU_REQ:  if (req_ready)  w_nextState = LSU_WAIT;
            LSU_WAIT: if (resp_valid) w_nextState = LSU_DONE;
            LSU_DONE: if (wb_allow_in) w_nextState = w_accept ? w_acceptTarget : LSU_IDLE;
            default:  w_nextState = LSU_IDLE;
        endcase
    end

    always_comb begin
        lsu_allow_in    = 1'b0;
        lsu_to_wb_valid = 1'b0;
        req_valid       = 1'b0;
        case (r_state)
            LSU_IDLE: lsu_allow_in = 1'b1;
            LSU_REQ:  req_valid    = 1'b1;
            LSU_DONE: begin
                lsu_allow_in    = wb_allow_in;
                lsu_to_wb_valid = 1'b1;
            end
            default: ;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_rdata  (resp_rdata),
        .i_offset (r_addr[2:0]),
        .i_MemOP  (r_memOp),
        .o_data   (w_loadData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_wen        <= 1'b0;
            r_memRd      <= 1'b0;
            r_memOp      <= '0;
            r_memOut     <= '0;
            r_RegSrc     <= 1'b0;
            r_RegWr      <= 1'b0;
            r_isecall    <= 1'b0;
            r_ismret     <= 1'b0;
            r_iscsr      <= 1'b0;
            r_clint_mtip <= 1'b0;
            r_R_rs1      <= '0;
            r_pc         <= '0;
            r_inst       <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_addr       <= i_ALUres;
            r_wdata      <= w_storeData;
            r_wmask      <= w_storeMask;
            r_wen        <= i_MemWr;
            r_memRd      <= i_MemRd;
            r_memOp      <= i_MemOP;
            r_memOut     <= '0;
            r_RegSrc     <= i_RegSrc;
            r_RegWr      <= i_RegWr;
            r_isecall    <= i_isecall;
            r_ismret     <= i_ismret;
            r_iscsr      <= i_iscsr;
            r_clint_mtip <= i_clint_mtip;
            r_R_rs1      <= i_R_rs1;
            r_pc         <= i_pc;
            r_inst       <= i_inst;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign   <= w_misalign;
`endif
        end else if (r_state == LSU_WAIT && resp_valid) begin
            r_memOut <= r_memRd ? w_loadData : '0;
        end
    end

    assign req_wen      = r_wen;
    assign req_addr     = {r_addr[XLEN-1:3], 3'b000};
    assign req_wdata    = r_wdata;
    assign req_wmask    = r_wmask;
    assign MemOut       = r_memOut;
    assign o_ALUres     = r_addr;
    assign o_RegSrc     = r_RegSrc;
    assign o_RegWr      = r_RegWr;
    assign o_isecall    = r_isecall;
    assign o_ismret     = r_ismret;
    assign o_iscsr      = r_iscsr;
    assign o_clint_mtip = r_clint_mtip;
    assign o_R_rs1      = r_R_rs1;
    assign o_pc         = r_pc;
    assign o_inst       = r_inst;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: handshake, load alignment, store lanes, stalls, reset.
// Build with LSU_MISALIGN_CHECK_EN defined to exercise the alignment trap path.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_to_lsu_valid, lsu_allow_in;
    logic [63:0] i_ALUres, i_R_rs2, i_R_rs1, i_pc;
    logic        i_MemRd, i_MemWr;
    logic [2:0]  i_MemOP;
    logic        i_RegSrc, i_RegWr, i_isecall, i_ismret, i_iscsr, i_clint_mtip;
    logic [31:0] i_inst;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        lsu_to_wb_valid, wb_allow_in;
    logic [63:0] MemOut, o_ALUres, o_R_rs1, o_pc;
    logic        o_misalign, o_RegSrc, o_RegWr, o_isecall, o_ismret, o_iscsr, o_clint_mtip;
    logic [31:0] o_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .rst(rst),
        .ex_to_lsu_valid(ex_to_lsu_valid), .lsu_allow_in(lsu_allow_in),
        .i_ALUres(i_ALUres), .i_R_rs2(i_R_rs2), .i_MemRd(i_MemRd), .i_MemWr(i_MemWr),
        .i_MemOP(i_MemOP), .i_RegSrc(i_RegSrc), .i_RegWr(i_RegWr), .i_isecall(i_isecall),
        .i_ismret(i_ismret), .i_iscsr(i_iscsr), .i_clint_mtip(i_clint_mtip),
        .i_R_rs1(i_R_rs1), .i_pc(i_pc), .i_inst(i_inst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .lsu_to_wb_valid(lsu_to_wb_valid), .wb_allow_in(wb_allow_in),
        .MemOut(MemOut), .o_misalign(o_misalign), .o_ALUres(o_ALUres),
        .o_RegSrc(o_RegSrc), .o_RegWr(o_RegWr), .o_isecall(o_isecall),
        .o_ismret(o_ismret), .o_iscsr(o_iscsr), .o_clint_mtip(o_clint_mtip),
        .o_R_rs1(o_R_rs1), .o_pc(o_pc), .o_inst(o_inst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] op,
                                 input logic [63:0] addr, input logic [63:0] rs2);
        ex_to_lsu_valid = 1'b1;
        i_MemRd  = rd;
        i_MemWr  = wr;
        i_MemOP  = op;
        i_ALUres = addr;
        i_R_rs2  = rs2;
    endtask

    // Full load with zero-wait ready and response; WB accepts immediately.
    task automatic doLoad(input string tag, input logic [2:0] op, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] expMem);
        applyStimulus(1'b1, 1'b0, op, addr, 64'h0);
        tick();
        ex_to_lsu_valid = 1'b0;
        checkOutput({tag, "_req_valid"}, {63'b0, req_valid}, 64'd1);
        checkOutput({tag, "_req_addr"}, req_addr, addr & ~64'h7);
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = rdata;
        tick();
        resp_valid = 1'b0;
        checkOutput({tag, "_wb_valid"}, {63'b0, lsu_to_wb_valid}, 64'd1);
        checkOutput({tag, "_MemOut"}, MemOut, expMem);
        tick();
        checkOutput({tag, "_idle"}, {63'b0, lsu_to_wb_valid}, 64'd0);
    endtask

    task automatic doStore(input string tag, input logic [2:0] op, input logic [63:0] addr,
                           input logic [63:0] rs2, input logic [7:0] expMask, input logic [63:0] expData);
        applyStimulus(1'b0, 1'b1, op, addr, rs2);
        tick();
        ex_to_lsu_valid = 1'b0;
        checkOutput({tag, "_req_valid"}, {63'b0, req_valid}, 64'd1);
        checkOutput({tag, "_req_wen"}, {63'b0, req_wen}, 64'd1);
        checkOutput({tag, "_req_wmask"}, {56'b0, req_wmask}, {56'b0, expMask});
        checkOutput({tag, "_req_wdata"}, req_wdata, expData);
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        resp_valid = 1'b0;
        checkOutput({tag, "_MemOut"}, MemOut, 64'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ex_to_lsu_valid = 1'b0;
        i_ALUres = '0; i_R_rs2 = '0; i_R_rs1 = '0; i_pc = '0; i_inst = '0;
        i_MemRd = 1'b0; i_MemWr = 1'b0; i_MemOP = '0;
        i_RegSrc = 1'b0; i_RegWr = 1'b0; i_isecall = 1'b0; i_ismret = 1'b0;
        i_iscsr = 1'b0; i_clint_mtip = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; wb_allow_in = 1'b1;

        tick();
        tick();
        checkOutput("rst_allow_in", {63'b0, lsu_allow_in}, 64'd1);
        checkOutput("rst_wb_valid", {63'b0, lsu_to_wb_valid}, 64'd0);
        checkOutput("rst_req_valid", {63'b0, req_valid}, 64'd0);
        checkOutput("rst_MemOut", MemOut, 64'h0);
        rst = 1'b0;
        tick();

        $display("[TB] non-memory op");
        applyStimulus(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0);
        i_pc = 64'h8000_0100; i_inst = 32'h0013_0313; i_RegWr = 1'b1;
        tick();
        ex_to_lsu_valid = 1'b0;
        checkOutput("nonmem_wb_valid", {63'b0, lsu_to_wb_valid}, 64'd1);
        checkOutput("nonmem_ALUres", o_ALUres, 64'h1234);
        checkOutput("nonmem_MemOut", MemOut, 64'h0);
        checkOutput("nonmem_pc", o_pc, 64'h8000_0100);
        checkOutput("nonmem_inst", {32'b0, o_inst}, 64'h0013_0313);
        checkOutput("nonmem_req_valid", {63'b0, req_valid}, 64'd0);
        tick();
        checkOutput("nonmem_idle", {63'b0, lsu_to_wb_valid}, 64'd0);

        $display("[TB] load alignment");
        doLoad("lb",  3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        doLoad("lbu", 3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        doLoad("lh",  3'b001, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF);
        doLoad("lhu", 3'b101, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
        doLoad("lw",  3'b010, 64'h0000_1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        doLoad("lwu", 3'b110, 64'h0000_1004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        doLoad("op7", 3'b111, 64'h0000_0010, 64'hA5A5_0000_1111_2222, 64'hA5A5_0000_1111_2222);

        $display("[TB] store lanes with ready and WB stalls");
        applyStimulus(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
        tick();
        ex_to_lsu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sh_req_valid", {63'b0, req_valid}, 64'd1);
            checkOutput("sh_req_wmask", {56'b0, req_wmask}, 64'hC0);
            checkOutput("sh_req_wdata", req_wdata, 64'hBEEF_0000_0000_0000);
            checkOutput("sh_req_addr", req_addr, 64'h8000_0000);
            checkOutput("sh_allow_in", {63'b0, lsu_allow_in}, 64'd0);
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checkOutput("sh_wait_req_valid", {63'b0, req_valid}, 64'd0);
        wb_allow_in = 1'b0;
        resp_valid  = 1'b1;
        resp_rdata  = 64'h1234_5678_9ABC_DEF0;
        tick();
        resp_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'b000, 64'hDEAD, 64'h0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stall_wb_valid", {63'b0, lsu_to_wb_valid}, 64'd1);
            checkOutput("stall_allow_in", {63'b0, lsu_allow_in}, 64'd0);
            checkOutput("stall_ALUres", o_ALUres, 64'h8000_0006);
            checkOutput("stall_MemOut", MemOut, 64'h0);
            tick();
        end
        ex_to_lsu_valid = 1'b0;
        wb_allow_in = 1'b1;
        tick();
        checkOutput("stall_release_idle", {63'b0, lsu_to_wb_valid}, 64'd0);

        $display("[TB] back-to-back loads and reset in WAIT");
        applyStimulus(1'b1, 1'b0, 3'b010, 64'h0000_1000, 64'h0);
        tick();
        ex_to_lsu_valid = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 64'h1111_2222_8765_4321;
        tick();
        resp_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'b011, 64'h0000_2008, 64'h0);
        #1;
        checkOutput("b2b_first_valid", {63'b0, lsu_to_wb_valid}, 64'd1);
        checkOutput("b2b_first_MemOut", MemOut, 64'hFFFF_FFFF_8765_4321);
        checkOutput("b2b_allow_in", {63'b0, lsu_allow_in}, 64'd1);
        tick();
        ex_to_lsu_valid = 1'b0;
        checkOutput("b2b_second_req", {63'b0, req_valid}, 64'd1);
        checkOutput("b2b_second_addr", req_addr, 64'h0000_2008);
        checkOutput("b2b_wb_valid_low", {63'b0, lsu_to_wb_valid}, 64'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstwait_allow_in", {63'b0, lsu_allow_in}, 64'd1);
        checkOutput("rstwait_wb_valid", {63'b0, lsu_to_wb_valid}, 64'd0);
        checkOutput("rstwait_req_valid", {63'b0, req_valid}, 64'd0);
        checkOutput("rstwait_ALUres", o_ALUres, 64'h0);
        tick();
        rst = 1'b0;
        tick();

`ifdef LSU_MISALIGN_CHECK_EN
        $display("[TB] misaligned word load is trapped");
        applyStimulus(1'b1, 1'b0, 3'b010, 64'h0000_3002, 64'h0);
        tick();
        ex_to_lsu_valid = 1'b0;
        checkOutput("mis_req_valid", {63'b0, req_valid}, 64'd0);
        checkOutput("mis_wb_valid", {63'b0, lsu_to_wb_valid}, 64'd1);
        checkOutput("mis_flag", {63'b0, o_misalign}, 64'd1);
        checkOutput("mis_MemOut", MemOut, 64'h0);
        tick();
        doStore("sw_aligned", 3'b010, 64'h0000_3004, 64'h0000_0000_CAFE_BABE, 8'hF0, 64'hCAFE_BABE_0000_0000);
        checkOutput("sw_aligned_flag", {63'b0, o_misalign}, 64'd0);
`else
        $display("[TB] unaligned accesses issued without trap");
        doLoad("lw_off2", 3'b010, 64'h0000_3002, 64'h0000_DEAD_BEEF_0000, 64'hFFFF_FFFF_DEAD_BEEF);
        checkOutput("lw_off2_flag", {63'b0, o_misalign}, 64'd0);
        doStore("sw_off2", 3'b010, 64'h0000_3002, 64'h0000_0000_CAFE_BABE, 8'h3C, 64'h0000_CAFE_BABE_0000);
        doStore("sw_off6", 3'b010, 64'h0000_3006, 64'h0000_0000_CAFE_BABE, 8'hC0, 64'hBABE_0000_0000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
